// File: rtl/serial_twos_receiver.sv
// Serial-to-parallel receiver for an LSB-first two's-complement bit stream.
// Presents the raw received word and the operand recovered by re-complementing it on the fly.
module serial_twos_receiver #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             reset_b,
  input  logic             start,
  input  logic             shift_control,
  input  logic             y,
  output logic [WIDTH-1:0] raw_word,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             busy,
  output logic             frame_err
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             flag_reg, flag_next;
  logic [WIDTH-1:0] raw_reg, raw_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic             valid_reg, valid_next;
  logic             err_reg, err_next;

  logic [WIDTH-1:0] raw_shifted;
  logic [WIDTH-1:0] data_shifted;

  // Incoming bit enters at the MSB; the recovered bit is inverted once a 1 has been seen.
  assign raw_shifted[WIDTH-1]  = y;
  assign data_shifted[WIDTH-1] = y ^ flag_reg;

  for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
    assign raw_shifted[gi]  = raw_reg[gi+1];
    assign data_shifted[gi] = data_reg[gi+1];
  end

  always_ff @(posedge Clock or negedge reset_b) begin
    if (!reset_b) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      flag_reg  <= 1'b0;
      raw_reg   <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      flag_reg  <= flag_next;
      raw_reg   <= raw_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    flag_next  = flag_reg;
    raw_next   = raw_reg;
    data_next  = data_reg;
    valid_next = 1'b0;
    err_next   = err_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RECV;
          cnt_next   = '0;
          flag_next  = 1'b0;
        end
      end

      RECV: begin
        // A start mid-frame wins over any bit offered in the same cycle, including the last one.
        if (start) begin
          err_next  = 1'b1;
          cnt_next  = '0;
          flag_next = 1'b0;
        end else if (shift_control) begin
          raw_next  = raw_shifted;
          data_next = data_shifted;
          flag_next = flag_reg | y;
          cnt_next  = cnt_reg + CNT_W'(1);
          if (cnt_reg == LAST_BIT) begin
            state_next = IDLE;
            valid_next = 1'b1;
            cnt_next   = '0;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign raw_word  = raw_reg;
  assign data      = data_reg;
  assign valid     = valid_reg;
  assign busy      = (state_reg == RECV);
  assign frame_err = err_reg;

endmodule

// File: tb/tb_serial_twos_receiver.sv
// Bench for serial_twos_receiver: frame-level reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_serial_twos_receiver;

  localparam int W = 8;

  logic         Clock = 1'b0;
  logic         reset_b = 1'b0;
  logic         start = 1'b0;
  logic         shift_control = 1'b0;
  logic         y = 1'b0;
  logic [W-1:0] raw_word;
  logic [W-1:0] data;
  logic         valid;
  logic         busy;
  logic         frame_err;

  int checks = 0;
  int errors = 0;

  serial_twos_receiver #(.WIDTH(W)) dut (
    .Clock         (Clock),
    .reset_b       (reset_b),
    .start         (start),
    .shift_control (shift_control),
    .y             (y),
    .raw_word      (raw_word),
    .data          (data),
    .valid         (valid),
    .busy          (busy),
    .frame_err     (frame_err)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collects accepted bits into a word; recovered operand is its negation.
  bit           m_in_frame = 1'b0;
  int           m_nb = 0;
  logic [W-1:0] m_acc = '0;
  logic         m_valid = 1'b0;
  logic         m_busy = 1'b0;
  logic         m_err = 1'b0;
  logic [W-1:0] m_raw = '0;
  logic [W-1:0] m_data = '0;
  int           cyc_n = 0;
  int           m_start_cyc = 0;
  int           m_latency = 0;

  always @(posedge Clock or negedge reset_b) begin
    if (!reset_b) begin
      m_in_frame = 1'b0;
      m_nb       = 0;
      m_acc      = '0;
      m_valid    = 1'b0;
      m_busy     = 1'b0;
      m_err      = 1'b0;
    end else begin
      cyc_n++;
      m_valid = 1'b0;
      if (start) begin
        if (m_in_frame) m_err = 1'b1;
        m_in_frame  = 1'b1;
        m_nb        = 0;
        m_acc       = '0;
        m_start_cyc = cyc_n;
      end else if (m_in_frame && shift_control) begin
        m_acc[m_nb] = y;
        m_nb++;
        if (m_nb == W) begin
          m_in_frame = 1'b0;
          m_valid    = 1'b1;
          m_raw      = m_acc;
          m_data     = -m_acc;
          m_latency  = cyc_n - m_start_cyc;
        end
      end
      m_busy = m_in_frame;
    end
  end

  // Per-cycle compare, sampled on the falling edge.
  int           n_valid = 0;
  logic [W-1:0] last_raw = '0;
  logic [W-1:0] last_data = '0;
  logic [W-1:0] prev_data = '0;
  int           last_lat = 0;

  always @(negedge Clock) begin
    check("valid", 32'(valid), 32'(m_valid));
    check("busy", 32'(busy), 32'(m_busy));
    check("frame_err", 32'(frame_err), 32'(m_err));
    if (m_valid) begin
      check("raw_word", 32'(raw_word), 32'(m_raw));
      check("data", 32'(data), 32'(m_data));
      n_valid++;
      prev_data = last_data;
      last_raw  = raw_word;
      last_data = data;
      last_lat  = m_latency;
      $display("frame %0d: raw_word=%h data=%h latency=%0d err=%0b",
               n_valid, raw_word, data, m_latency, frame_err);
    end
  end

  task automatic cyc(input logic st, input logic sc, input logic yy);
    @(posedge Clock);
    #1;
    start = st;
    shift_control = sc;
    y = yy;
  endtask

  task automatic send_bits(input logic [W-1:0] v);
    for (int i = 0; i < W; i++) cyc(1'b0, 1'b1, v[i]);
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  int nv0;

  initial begin
    // Reset state
    settle(3);
    check("reset raw_word", 32'(raw_word), 32'h0);
    check("reset data", 32'(data), 32'h0);
    check("reset valid", 32'(valid), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset frame_err", 32'(frame_err), 32'h0);
    @(posedge Clock);
    #1 reset_b = 1'b1;
    settle(2);

    // Basic 0xA6 frame
    nv0 = n_valid;
    cyc(1'b1, 1'b0, 1'b0);
    send_bits(8'hA6);
    settle(3);
    check("a6 nvalid", 32'(n_valid - nv0), 32'd1);
    check("a6 raw", 32'(last_raw), 32'hA6);
    check("a6 data", 32'(last_data), 32'h5A);
    check("a6 latency", 32'(last_lat), 32'd8);
    check("a6 busy after", 32'(busy), 32'h0);

    // All-zero and 0x80 frames
    cyc(1'b1, 1'b0, 1'b0);
    send_bits(8'h00);
    settle(2);
    check("zero raw", 32'(last_raw), 32'h00);
    check("zero data", 32'(last_data), 32'h00);
    cyc(1'b1, 1'b0, 1'b0);
    send_bits(8'h80);
    settle(2);
    check("x80 raw", 32'(last_raw), 32'h80);
    check("x80 data", 32'(last_data), 32'h80);

    // Gapped 0xA6 frame
    nv0 = n_valid;
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < W; i++) begin
      cyc(1'b0, 1'b1, 1'(8'hA6 >> i));
      if (i == 2) settle(3);
      if (i == 5) settle(1);
    end
    settle(3);
    check("gap nvalid", 32'(n_valid - nv0), 32'd1);
    check("gap data", 32'(last_data), 32'h5A);
    check("gap latency", 32'(last_lat), 32'd12);

    // Back-to-back with start in the valid cycle
    nv0 = n_valid;
    cyc(1'b1, 1'b0, 1'b0);
    send_bits(8'hA6);
    cyc(1'b1, 1'b0, 1'b0);
    send_bits(8'hFF);
    settle(3);
    check("b2b nvalid", 32'(n_valid - nv0), 32'd2);
    check("b2b first data", 32'(prev_data), 32'h5A);
    check("b2b second data", 32'(last_data), 32'h01);
    check("b2b frame_err", 32'(frame_err), 32'h0);

    // Abort after 4 bits, then a full frame
    nv0 = n_valid;
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    send_bits(8'hA6);
    settle(3);
    check("abort nvalid", 32'(n_valid - nv0), 32'd1);
    check("abort data", 32'(last_data), 32'h5A);
    check("abort frame_err", 32'(frame_err), 32'h1);
    settle(5);
    check("abort err sticky", 32'(frame_err), 32'h1);

    // Start coinciding with the final bit aborts that frame
    nv0 = n_valid;
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < W - 1; i++) cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    send_bits(8'h80);
    settle(3);
    check("lastbit abort nvalid", 32'(n_valid - nv0), 32'd1);
    check("lastbit abort data", 32'(last_data), 32'h80);

    // Reset mid-frame, stray shifts, then a clean frame
    nv0 = n_valid;
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b1);
    @(posedge Clock);
    #1;
    reset_b = 1'b0;
    start = 1'b0;
    shift_control = 1'b0;
    settle(2);
    @(posedge Clock);
    #1 reset_b = 1'b1;
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1);
    settle(2);
    check("rst nvalid", 32'(n_valid - nv0), 32'd0);
    check("rst raw", 32'(raw_word), 32'h0);
    check("rst data", 32'(data), 32'h0);
    check("rst busy", 32'(busy), 32'h0);
    check("rst frame_err", 32'(frame_err), 32'h0);
    cyc(1'b1, 1'b0, 1'b0);
    send_bits(8'hA6);
    settle(3);
    check("post-rst nvalid", 32'(n_valid - nv0), 32'd1);
    check("post-rst data", 32'(last_data), 32'h5A);

    // Randomized traffic
    for (int i = 0; i < 3000; i++)
      cyc(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    settle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_twos_receiver.md
# serial_twos_receiver

Serial-to-parallel receiver for the LSB-first two's-complement bit stream produced by the serial two's complementer. It captures one WIDTH-bit frame on `y` under `shift_control`. It presents two values: the raw received word, and the original operand recovered by re-applying the serial complement rule on the fly (two's complement is its own inverse). It sits at the far end of the serial link and hands completed words to parallel logic with a one-cycle `valid` pulse.

## Interface
- WIDTH, 8, frame length in bits (≥2)
- Clock  input  1  rising-edge clock for all state
- reset_b  input  1  one clock; reset is asynchronous and active-low
- start  input  1  arm a new frame; sampled on Clock
- shift_control  input  1  `y` holds a valid bit this cycle
- y  input  1  serial data, LSB first
- raw_word  output  WIDTH  received bits as sent (complemented value)
- data  output  WIDTH  recovered original operand = two's complement of raw_word
- valid  output  1  one-cycle pulse: raw_word/data hold a complete frame
- busy  output  1  high while a frame is being received
- frame_err  output  1  sticky: a frame was aborted by a new start

## Operation
- States: IDLE, RECV. Internal registers: bit counter (clog2(WIDTH) bits) and `flag` (a 1 has been seen).
- IDLE:
  - `start`=1 moves to RECV and clears counter and flag.
  - `shift_control` is ignored in IDLE and in the cycle that `start` is sampled.
- RECV, each edge with `shift_control`=1:
  - raw_word <= {y, raw_word[WIDTH-1:1]}
  - data <= {y^flag, data[WIDTH-1:1]}
  - flag <= flag | y
  - counter increments
- RECV, `shift_control`=0: state holds. Gaps of any length are legal.
- On the edge that accepts bit WIDTH-1:
  - state returns to IDLE and `valid` is set to 1 for exactly one cycle.
  - raw_word and data are then final and hold until the first shift of the next frame.
- `start`=1 while in RECV:
  - the frame is aborted and frame_err is set.
  - counter and flag are cleared and the block stays in RECV, so the new frame starts at once.
  - any `shift_control` in that cycle is ignored.
- frame_err clears only on reset.
- `start` in the same cycle as the final bit counts as an abort: the final bit is ignored, valid is not asserted, and frame_err is set.
- Reset values: raw_word=0, data=0, valid=0, busy=0, frame_err=0, state=IDLE, counter=0, flag=0.
- Reset asserted mid-frame clears everything immediately. The partial frame is lost and no valid is produced.

## Timing
- busy = (state==RECV), registered. It goes high the cycle after `start` is sampled and low the cycle after the final bit.
- Minimum frame: 1 start cycle + WIDTH shift cycles. `valid` is high in the cycle following the edge that captures bit WIDTH-1.
- Back-to-back frames: `start` may be asserted in the cycle where `valid` is high. The first bit of the new frame is accepted the cycle after that.
- raw_word/data shift visibly during reception. Consumers sample them only when `valid`=1.

## Test plan
- Reset then start, then bits 0,1,1,0,0,1,0,1 on consecutive cycles (0x5A complemented = 0xA6) -> valid one cycle; raw_word=0xA6, data=0x5A; busy low after.
- Frame of eight 0s -> raw_word=0x00, data=0x00. Frame 0x80 (bits 0×7 then 1) -> raw_word=0x80, data=0x80.
- 0xA6 frame with shift_control deasserted for 3 cycles after bit 2 and 1 cycle after bit 5 -> same result as the first scenario, valid delayed by 4 cycles.
- start, 4 bits, start again, then full 0xA6 frame -> frame_err=1 and stays 1; single valid with data=0x5A.
- reset_b low after bit 3, then released; shift_control pulses without start -> no valid, all outputs 0. A following start plus a full frame decodes correctly.
- Two frames back-to-back with start in the valid cycle (0xA6 then 0xFF) -> first valid data=0x5A, second valid data=0x01.
